// File: rtl/result_drain_reader_pkg.sv
// Shared definitions for the result drain path: FSM encoding and beat geometry helpers.
// Imported by the drain controller and its beat selector.
package result_drain_reader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        STREAM = 3'd3,
        FIN    = 3'd4
    } drain_state_t;

    function automatic int beats_per_row(input int matrix_size, input int lanes_per_beat);
        return matrix_size / lanes_per_beat;
    endfunction

    // A single-beat row still needs a one-bit counter to keep the datapath legal.
    function automatic int beat_cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int DEFAULT_MATRIX_SIZE    = 32;
    localparam int DEFAULT_LANES_PER_BEAT = 4;
    localparam int DEFAULT_BEATS          = beats_per_row(DEFAULT_MATRIX_SIZE, DEFAULT_LANES_PER_BEAT);
    localparam int BEAT_CNT_W             = beat_cnt_width(DEFAULT_BEATS);

endpackage

// File: rtl/result_drain_reader_beat_mux.sv
// Combinational beat selector: picks beat k (lanes k*LANES_PER_BEAT upward) from a captured row.
// Lowest-numbered lane of the beat lands in the least significant bits.
module result_beat_mux
    import result_drain_reader_pkg::*;
#(
    parameter int PARTIAL_SUM_BW = 24,
    parameter int MATRIX_SIZE    = 32,
    parameter int LANES_PER_BEAT = 4,
    parameter int BEAT_W         = 3
) (
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]    row,
    input  logic [BEAT_W-1:0]                        beat,
    output logic [PARTIAL_SUM_BW*LANES_PER_BEAT-1:0] beat_data
);

    localparam int BEATS   = beats_per_row(MATRIX_SIZE, LANES_PER_BEAT);
    localparam int BEAT_BW = PARTIAL_SUM_BW * LANES_PER_BEAT;

    always_comb begin
        beat_data = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (beat == BEAT_W'(k)) begin
                beat_data = row[k*BEAT_BW +: BEAT_BW];
            end
        end
    end

endmodule

// File: rtl/result_drain_reader.sv
// Walks the results SRAM from a base address and serializes each row into
// fixed-width beats on a valid/ready stream. Owns the SRAM read port only.
module result_drain_reader
    import result_drain_reader_pkg::*;
#(
    parameter int ADDRESSSIZE    = 10,
    parameter int PARTIAL_SUM_BW = 24,
    parameter int MATRIX_SIZE    = 32,
    parameter int LANES_PER_BEAT = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [ADDRESSSIZE-1:0]                   base_address,
    input  logic [ADDRESSSIZE:0]                     num_rows,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     rd_enable,
    output logic [ADDRESSSIZE-1:0]                   rd_address,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0]    rd_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [PARTIAL_SUM_BW*LANES_PER_BEAT-1:0] out_data,
    output logic                                     out_last
);

    localparam int BEATS  = beats_per_row(MATRIX_SIZE, LANES_PER_BEAT);
    localparam int BEAT_W = beat_cnt_width(BEATS);
    localparam int ROW_W  = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if ((MATRIX_SIZE % LANES_PER_BEAT) != 0) begin : g_geometry_check
        $error("LANES_PER_BEAT must divide MATRIX_SIZE");
    end

    drain_state_t             state;
    logic [ADDRESSSIZE-1:0]   base_q;
    logic [ADDRESSSIZE:0]     num_rows_q;
    logic [ADDRESSSIZE:0]     row_idx;
    logic                     last_row_q;
    logic [BEAT_W-1:0]        beat;
    logic [ROW_W-1:0]         row_q;

    logic [ADDRESSSIZE:0]     next_row;
    logic [ADDRESSSIZE-1:0]   next_address;
    logic [BEAT_W-1:0]        beat_next;
    logic                     handshake;
    logic                     final_beat;

    // Row addresses wrap modulo 2^ADDRESSSIZE through plain truncating addition.
    assign next_row     = row_idx + (ADDRESSSIZE+1)'(1);
    assign next_address = base_q + next_row[ADDRESSSIZE-1:0];
    assign beat_next    = beat + BEAT_W'(1);
    assign handshake    = out_valid & out_ready;
    assign final_beat   = (beat == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_enable  <= 1'b0;
            rd_address <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            base_q     <= '0;
            num_rows_q <= '0;
            row_idx    <= '0;
            last_row_q <= 1'b0;
            beat       <= '0;
            row_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_rows != '0) begin
                            base_q     <= base_address;
                            num_rows_q <= num_rows;
                            row_idx    <= '0;
                            rd_enable  <= 1'b1;
                            rd_address <= base_address;
                            state      <= ISSUE;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end

                ISSUE: begin
                    rd_enable  <= 1'b0;
                    last_row_q <= (next_row == num_rows_q);
                    state      <= WAIT;
                end

                // SRAM data is valid now, one cycle after the read strobe.
                WAIT: begin
                    row_q     <= rd_data;
                    beat      <= '0;
                    out_valid <= 1'b1;
                    out_last  <= last_row_q && (BEATS == 1);
                    state     <= STREAM;
                end

                STREAM: begin
                    if (handshake) begin
                        if (final_beat) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (last_row_q) begin
                                done  <= 1'b1;
                                state <= FIN;
                            end else begin
                                row_idx    <= next_row;
                                rd_enable  <= 1'b1;
                                rd_address <= next_address;
                                state      <= ISSUE;
                            end
                        end else begin
                            beat     <= beat_next;
                            out_last <= last_row_q && (beat_next == LAST_BEAT);
                        end
                    end
                end

                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    rd_enable <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

    // Beat payload follows the held row and beat counter, so it is stable under backpressure.
    result_beat_mux #(
        .PARTIAL_SUM_BW (PARTIAL_SUM_BW),
        .MATRIX_SIZE    (MATRIX_SIZE),
        .LANES_PER_BEAT (LANES_PER_BEAT),
        .BEAT_W         (BEAT_W)
    ) u_beat_mux (
        .row       (row_q),
        .beat      (beat),
        .beat_data (out_data)
    );

endmodule
